// File: rtl/parser_pkg.sv
// Shared message/response encodings between the RX parser, the command
// dispatcher and the TX formatter, plus the burst size rule.
package parser_pkg;

    localparam int DIM_W = 12;

    typedef enum logic [3:0] {
        MSG_NONE            = 4'd0,
        MSG_RGF_WRITE       = 4'd1,
        MSG_RGF_READ        = 4'd2,
        MSG_SINGLE_PIXEL_WR = 4'd3,
        MSG_START_BURST_WR  = 4'd4,
        MSG_BURST_PIXEL_WR  = 4'd5,
        MSG_START_BURST_RD  = 4'd6,
        MSG_INVALID         = 4'd15
    } msg_type_e;

    typedef enum logic [1:0] {
        RSP_ACK  = 2'd0,
        RSP_DATA = 2'd1,
        RSP_NAK  = 2'd2
    } rsp_type_e;

    function automatic logic [2*DIM_W-1:0] burst_area(input logic [DIM_W-1:0] h,
                                                      input logic [DIM_W-1:0] w);
        return (2*DIM_W)'(h) * (2*DIM_W)'(w);
    endfunction

    // A frame of exactly 2^pix_addr_w pixels still fits the pixel memory.
    function automatic logic burst_size_ok(input logic [DIM_W-1:0] h,
                                           input logic [DIM_W-1:0] w,
                                           input int unsigned      pix_addr_w);
        return (h != '0) && (w != '0) &&
               (32'(burst_area(h, w)) <= (32'd1 << pix_addr_w));
    endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_pix_addr_gen.sv
// Pixel address counter for burst writes: tracks the next address and how
// many pixels of the frame are still outstanding.
module pix_addr_gen #(
    parameter int PIX_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [PIX_ADDR_W:0]   total_i,
    input  logic                  inc_i,
    output logic [PIX_ADDR_W-1:0] addr_o,
    output logic                  last_o
);

    logic [PIX_ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_ADDR_W:0]   remain_q, remain_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        addr_d   = addr_q;
        remain_d = remain_q;
        if (clear_i) begin
            addr_d   = '0;
            remain_d = '0;
        end else if (load_i) begin
            addr_d   = '0;
            remain_d = total_i;
        end else if (inc_i && (remain_q != '0)) begin
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (remain_q == (PIX_ADDR_W+1)'(1));

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Runs one parsed UART command at a time against the RGF, pixel memory and
// burst-read engine, and returns exactly one response per command.
module uart_cmd_dispatcher
    import parser_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int PIX_W      = 24,
    parameter int PIX_ADDR_W = 17,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [3:0]            msg_type,
    input  logic [ADDR_W-1:0]     msg_addr,
    input  logic [DATA_W-1:0]     msg_data,
    input  logic [DIM_W-1:0]      msg_h,
    input  logic [DIM_W-1:0]      msg_w,
    input  logic [4*PIX_W-1:0]    msg_pix,
    output logic                  rgf_wr_en,
    output logic                  rgf_rd_en,
    output logic [ADDR_W-1:0]     rgf_addr,
    output logic [DATA_W-1:0]     rgf_wdata,
    input  logic [DATA_W-1:0]     rgf_rdata,
    input  logic                  rgf_rvalid,
    output logic                  pix_wr_en,
    output logic [PIX_ADDR_W-1:0] pix_wr_addr,
    output logic [PIX_W-1:0]      pix_wr_data,
    input  logic                  pix_wr_ready,
    output logic                  rd_start,
    output logic [DIM_W-1:0]      rd_h,
    output logic [DIM_W-1:0]      rd_w,
    output logic [PIX_ADDR_W-1:0] rd_addr,
    input  logic                  rd_busy,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_type,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  burst_active
);

    typedef enum logic [3:0] {
        S_IDLE, S_RGF_WR, S_RGF_RD, S_PIX_WR, S_BURST_WAIT,
        S_BURST_WR, S_RD_LAUNCH, S_RD_WAIT, S_RSP
    } state_e;

    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [4*PIX_W-1:0]    pix_q, pix_d;
    logic [1:0]            idx_q, idx_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  busy_seen_q, busy_seen_d;
    logic                  burst_q, burst_d;
    logic                  live_q;
    rsp_type_e             rsp_type_q, rsp_type_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic [DIM_W-1:0]      rd_h_q, rd_h_d, rd_w_q, rd_w_d;
    logic [PIX_ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic                  accept, size_ok, rsp_go;
    rsp_type_e             rsp_kind;
    logic                  gen_clear, gen_load, gen_inc, gen_last;
    logic [PIX_ADDR_W-1:0] gen_addr;

    // live_q keeps msg_ready low while reset is held and for the first cycle after.
    assign msg_ready = live_q && ((state_q == S_IDLE) || (state_q == S_BURST_WAIT));
    assign accept    = msg_valid && msg_ready;
    assign size_ok   = burst_size_ok(msg_h, msg_w, PIX_ADDR_W);

    pix_addr_gen #(.PIX_ADDR_W(PIX_ADDR_W)) u_pix_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (gen_clear),
        .load_i  (gen_load),
        .total_i ((PIX_ADDR_W+1)'(burst_area(msg_h, msg_w))),
        .inc_i   (gen_inc),
        .addr_o  (gen_addr),
        .last_o  (gen_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pix_d       = pix_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        busy_seen_d = busy_seen_q;
        burst_d     = burst_q;
        rsp_type_d  = rsp_type_q;
        rsp_data_d  = rsp_data_q;
        rd_h_d      = rd_h_q;
        rd_w_d      = rd_w_q;
        rd_addr_d   = rd_addr_q;
        rsp_go      = 1'b0;
        rsp_kind    = RSP_ACK;
        gen_clear   = 1'b0;
        gen_load    = 1'b0;
        gen_inc     = 1'b0;
        rgf_wr_en   = 1'b0;
        rgf_rd_en   = 1'b0;
        pix_wr_en   = 1'b0;
        rd_start    = 1'b0;

        case (state_q)
            S_IDLE: if (accept) begin
                case (msg_type)
                    MSG_RGF_WRITE: begin
                        addr_d  = msg_addr;
                        wdata_d = msg_data;
                        state_d = S_RGF_WR;
                    end
                    MSG_RGF_READ: begin
                        addr_d  = msg_addr;
                        tmr_d   = '0;
                        state_d = S_RGF_RD;
                    end
                    MSG_SINGLE_PIXEL_WR: begin
                        addr_d  = msg_addr;
                        pix_d   = msg_pix;
                        idx_d   = '0;
                        state_d = S_PIX_WR;
                    end
                    MSG_START_BURST_WR: begin
                        rsp_go   = 1'b1;
                        rsp_kind = size_ok ? RSP_ACK : RSP_NAK;
                        gen_load = size_ok;
                        burst_d  = size_ok;
                    end
                    MSG_START_BURST_RD: begin
                        if (size_ok) begin
                            rd_h_d      = msg_h;
                            rd_w_d      = msg_w;
                            rd_addr_d   = PIX_ADDR_W'(msg_addr);
                            busy_seen_d = 1'b0;
                            state_d     = S_RD_LAUNCH;
                        end else begin
                            rsp_go   = 1'b1;
                            rsp_kind = RSP_NAK;
                        end
                    end
                    default: begin
                        rsp_go   = 1'b1;
                        rsp_kind = RSP_NAK;
                    end
                endcase
            end
            S_RGF_WR: begin
                rgf_wr_en = 1'b1;
                rsp_go    = 1'b1;
            end
            S_RGF_RD: begin
                rgf_rd_en = (tmr_q == '0);
                tmr_d     = tmr_q + 1'b1;
                // A late rvalid landing on the final timeout cycle still returns data.
                if (rgf_rvalid) begin
                    rsp_go   = 1'b1;
                    rsp_kind = RSP_DATA;
                end else if (tmr_q == TMR_W'(RD_TIMEOUT - 1)) begin
                    rsp_go   = 1'b1;
                    rsp_kind = RSP_NAK;
                end
            end
            S_PIX_WR: begin
                pix_wr_en = 1'b1;
                rsp_go    = pix_wr_ready;
            end
            S_BURST_WAIT: if (accept) begin
                if (msg_type == MSG_BURST_PIXEL_WR) begin
                    pix_d   = msg_pix;
                    idx_d   = '0;
                    state_d = S_BURST_WR;
                end else begin
                    gen_clear = 1'b1;
                    burst_d   = 1'b0;
                    rsp_go    = 1'b1;
                    rsp_kind  = RSP_NAK;
                end
            end
            S_BURST_WR: begin
                pix_wr_en = 1'b1;
                if (pix_wr_ready) begin
                    gen_inc = 1'b1;
                    idx_d   = idx_q + 2'd1;
                    if (gen_last) begin
                        burst_d = 1'b0;
                        rsp_go  = 1'b1;
                    end else if (idx_q == 2'd3) begin
                        state_d = S_BURST_WAIT;
                    end
                end
            end
            S_RD_LAUNCH: if (!rd_busy) begin
                rd_start = 1'b1;
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    rsp_go = 1'b1;
                end
            end
            S_RSP: if (rsp_ready) begin
                state_d = burst_q ? S_BURST_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rsp_go) begin
            state_d    = S_RSP;
            rsp_type_d = rsp_kind;
            rsp_data_d = (rsp_kind == RSP_DATA) ? rgf_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            pix_q       <= '0;
            idx_q       <= '0;
            tmr_q       <= '0;
            busy_seen_q <= 1'b0;
            burst_q     <= 1'b0;
            live_q      <= 1'b0;
            rsp_type_q  <= RSP_ACK;
            rsp_data_q  <= '0;
            rd_h_q      <= '0;
            rd_w_q      <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pix_q       <= pix_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            busy_seen_q <= busy_seen_d;
            burst_q     <= burst_d;
            live_q      <= 1'b1;
            rsp_type_q  <= rsp_type_d;
            rsp_data_q  <= rsp_data_d;
            rd_h_q      <= rd_h_d;
            rd_w_q      <= rd_w_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign rgf_addr     = addr_q;
    assign rgf_wdata    = wdata_q;
    assign pix_wr_addr  = (state_q == S_PIX_WR) ? PIX_ADDR_W'(addr_q) : gen_addr;
    assign pix_wr_data  = pix_q[idx_q*PIX_W +: PIX_W];
    assign rd_h         = rd_h_q;
    assign rd_w         = rd_w_q;
    assign rd_addr      = rd_addr_q;
    assign rsp_valid    = (state_q == S_RSP);
    assign rsp_type     = rsp_type_q;
    assign rsp_data     = rsp_data_q;
    assign burst_active = burst_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Self-checking bench for uart_cmd_dispatcher: directed and randomized
// commands against a rule-level model of responses and pixel traffic.
module tb_uart_cmd_dispatcher;
    import parser_pkg::*;

    localparam int RD_TIMEOUT = 255;
    localparam int LIMIT      = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msg_valid, msg_ready;
    logic [3:0]  msg_type;
    logic [11:0] msg_addr, msg_h, msg_w;
    logic [15:0] msg_data;
    logic [95:0] msg_pix;
    logic        rgf_wr_en, rgf_rd_en, rgf_rvalid;
    logic [11:0] rgf_addr;
    logic [15:0] rgf_wdata, rgf_rdata;
    logic        pix_wr_en, pix_wr_ready;
    logic [16:0] pix_wr_addr;
    logic [23:0] pix_wr_data;
    logic        rd_start, rd_busy;
    logic [11:0] rd_h, rd_w;
    logic [16:0] rd_addr;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_type;
    logic [15:0] rsp_data;
    logic        burst_active;

    uart_cmd_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
        .msg_addr(msg_addr), .msg_data(msg_data), .msg_h(msg_h), .msg_w(msg_w),
        .msg_pix(msg_pix),
        .rgf_wr_en(rgf_wr_en), .rgf_rd_en(rgf_rd_en), .rgf_addr(rgf_addr),
        .rgf_wdata(rgf_wdata), .rgf_rdata(rgf_rdata), .rgf_rvalid(rgf_rvalid),
        .pix_wr_en(pix_wr_en), .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
        .pix_wr_ready(pix_wr_ready),
        .rd_start(rd_start), .rd_h(rd_h), .rd_w(rd_w), .rd_addr(rd_addr),
        .rd_busy(rd_busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_data(rsp_data), .burst_active(burst_active)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Observations taken on the falling edge, away from the active edge.
    int          wr_cnt = 0, rd_cnt = 0, start_cnt = 0, rsp_rise = 0, hold_err = 0;
    logic        prev_rsp_valid = 1'b0, pend = 1'b0;
    logic [16:0] pend_addr = '0;
    logic [23:0] pend_data = '0;
    logic [11:0] st_h = '0, st_w = '0;
    logic [16:0] st_addr = '0;
    logic [40:0] pix_log[$];
    int          ready_mode = 0;

    always @(negedge clk) begin
        prev_rsp_valid <= rsp_valid;
        if (rsp_valid && !prev_rsp_valid) rsp_rise <= rsp_rise + 1;
        if (rgf_wr_en) wr_cnt <= wr_cnt + 1;
        if (rgf_rd_en) rd_cnt <= rd_cnt + 1;
        if (rd_start) begin
            start_cnt <= start_cnt + 1;
            st_h      <= rd_h;
            st_w      <= rd_w;
            st_addr   <= rd_addr;
        end
        if (pix_wr_en && pix_wr_ready) pix_log.push_back({pix_wr_addr, pix_wr_data});
        if (rst_n && pend && (pix_wr_en !== 1'b1 || pix_wr_addr !== pend_addr ||
                              pix_wr_data !== pend_data))
            hold_err <= hold_err + 1;
        pend      <= rst_n && pix_wr_en && !pix_wr_ready;
        pend_addr <= pix_wr_addr;
        pend_data <= pix_wr_data;
    end

    initial begin
        pix_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_wr_ready = 1'b1;
                1:       pix_wr_ready = 1'($urandom_range(0, 1));
                default: pix_wr_ready = ~pix_wr_ready;
            endcase
        end
    end

    // Burst-read engine: goes busy the cycle after a launch, for three cycles.
    initial begin
        rd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_start) begin
                @(posedge clk);
                #1 rd_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 rd_busy = 1'b0;
            end
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [3:0] t, input logic [11:0] a, input logic [15:0] d,
                            input logic [11:0] h, input logic [11:0] w, input logic [95:0] p);
        int n = 0;
        msg_type = t; msg_addr = a; msg_data = d; msg_h = h; msg_w = w; msg_pix = p;
        msg_valid = 1'b1;
        while (!msg_ready && n < LIMIT) begin
            tick();
            n++;
        end
        check("msg_accepted_in_time", 32'(n < LIMIT), 1);
        if (n < LIMIT) tick();
        msg_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [1:0] et, input logic [15:0] ed);
        int          n = 0;
        logic [1:0]  t0;
        logic [15:0] d0;
        logic        stable = 1'b1;
        while (!rsp_valid && n < LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_rsp_seen"}, 32'(n < LIMIT), 1);
        t0 = rsp_type;
        d0 = rsp_data;
        repeat ($urandom_range(0, 2)) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_type !== t0 || rsp_data !== d0) stable = 1'b0;
        end
        check({tag, "_rsp_type"}, 32'(t0), 32'(et));
        if (et == RSP_DATA) check({tag, "_rsp_data"}, 32'(d0), 32'(ed));
        check({tag, "_rsp_stable"}, 32'(stable), 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic run_burst(input string tag, input int h, input int w);
        int          total = h * w;
        int          r0;
        logic [23:0] px[$];
        logic [95:0] grp;
        pix_log.delete();
        r0 = rsp_rise;
        send_msg(MSG_START_BURST_WR, 12'($urandom), 16'h0, 12'(h), 12'(w), 96'h0);
        get_rsp({tag, "_start"}, RSP_ACK, 16'h0);
        check({tag, "_active_open"}, 32'(burst_active), 1);
        for (int g = 0; g < (total + 3) / 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                grp[k*24 +: 24] = 24'($urandom);
                px.push_back(grp[k*24 +: 24]);
            end
            send_msg(MSG_BURST_PIXEL_WR, 12'($urandom), 16'($urandom), 12'h0, 12'h0, grp);
        end
        get_rsp({tag, "_done"}, RSP_ACK, 16'h0);
        check({tag, "_active_closed"}, 32'(burst_active), 0);
        check({tag, "_write_count"}, 32'(pix_log.size()), 32'(total));
        for (int i = 0; i < total && i < pix_log.size(); i++) begin
            check({tag, "_addr"}, 32'(pix_log[i][40:24]), 32'(i));
            check({tag, "_data"}, 32'(pix_log[i][23:0]), 32'(px[i]));
        end
        check({tag, "_response_count"}, 32'(rsp_rise - r0), 2);
        check({tag, "_hold_errors"}, 32'(hold_err), 0);
    endtask

    logic [11:0] ra;
    logic [15:0] rdv;
    logic [95:0] rp;
    int          n, c0, dly;

    initial begin
        rst_n = 1'b0; msg_valid = 1'b0; msg_type = '0; msg_addr = '0; msg_data = '0;
        msg_h = '0; msg_w = '0; msg_pix = '0; rgf_rdata = '0; rgf_rvalid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("reset_outputs_zero", 32'(|{msg_ready, rgf_wr_en, rgf_rd_en, rgf_addr, rgf_wdata,
              pix_wr_en, pix_wr_addr, pix_wr_data, rd_start, rd_h, rd_w, rd_addr, rsp_valid,
              rsp_type, rsp_data, burst_active}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(msg_ready), 1);

        // Directed RGF write.
        c0 = wr_cnt;
        send_msg(MSG_RGF_WRITE, 12'h012, 16'hBEEF, 12'h0, 12'h0, 96'h0);
        check("wr_strobe", 32'(rgf_wr_en), 1);
        check("wr_addr", 32'(rgf_addr), 32'h012);
        check("wr_data", 32'(rgf_wdata), 32'hBEEF);
        tick();
        check("wr_rsp_latency", 32'(rsp_valid), 1);
        get_rsp("wr", RSP_ACK, 16'h0);
        check("wr_strobe_count", 32'(wr_cnt - c0), 1);

        // Directed RGF read, rvalid three cycles after rd_en.
        c0 = rd_cnt;
        send_msg(MSG_RGF_READ, 12'h005, 16'h0, 12'h0, 12'h0, 96'h0);
        check("rd_strobe", 32'(rgf_rd_en), 1);
        check("rd_addr", 32'(rgf_addr), 32'h005);
        repeat (3) tick();
        rgf_rvalid = 1'b1; rgf_rdata = 16'h1234;
        check("rd_no_early_rsp", 32'(rsp_valid), 0);
        tick();
        rgf_rvalid = 1'b0;
        check("rd_rsp_latency", 32'(rsp_valid), 1);
        get_rsp("rd", RSP_DATA, 16'h1234);
        check("rd_strobe_count", 32'(rd_cnt - c0), 1);

        // Read timeout: NAK arrives RD_TIMEOUT cycles after the rd_en cycle.
        send_msg(MSG_RGF_READ, 12'h3A0, 16'h0, 12'h0, 12'h0, 96'h0);
        n = 0;
        while (!rsp_valid && n < LIMIT) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), RD_TIMEOUT);
        get_rsp("timeout", RSP_NAK, 16'h0);

        // rvalid on the last allowed cycle still wins over the timeout.
        send_msg(MSG_RGF_READ, 12'h3A1, 16'h0, 12'h0, 12'h0, 96'h0);
        repeat (RD_TIMEOUT - 1) tick();
        rgf_rvalid = 1'b1; rgf_rdata = 16'hC0DE;
        tick();
        rgf_rvalid = 1'b0;
        get_rsp("timeout_edge", RSP_DATA, 16'hC0DE);

        // Randomized RGF traffic.
        for (int i = 0; i < 8; i++) begin
            ra = 12'($urandom); rdv = 16'($urandom); dly = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) begin
                c0 = wr_cnt;
                send_msg(MSG_RGF_WRITE, ra, rdv, 12'h0, 12'h0, 96'h0);
                check("rnd_wr_addr", 32'(rgf_wr_en ? rgf_addr : ~ra), 32'(ra));
                check("rnd_wr_data", 32'(rgf_wdata), 32'(rdv));
                get_rsp("rnd_wr", RSP_ACK, 16'h0);
                check("rnd_wr_count", 32'(wr_cnt - c0), 1);
            end else begin
                send_msg(MSG_RGF_READ, ra, 16'h0, 12'h0, 12'h0, 96'h0);
                check("rnd_rd_addr", 32'(rgf_rd_en ? rgf_addr : ~ra), 32'(ra));
                repeat (dly) tick();
                rgf_rvalid = 1'b1; rgf_rdata = rdv;
                tick();
                rgf_rvalid = 1'b0;
                get_rsp("rnd_rd", RSP_DATA, rdv);
            end
        end

        // Image bursts: steady ready, 1-0-1 ready, random ready with random sizes.
        ready_mode = 0;
        run_burst("burst_2x3", 2, 3);
        ready_mode = 2;
        run_burst("burst_toggle", 2, 3);
        ready_mode = 1;
        for (int i = 0; i < 3; i++) run_burst("burst_rnd", $urandom_range(1, 5), $urandom_range(1, 5));
        ready_mode = 0;

        // Size checks, including the inclusive upper bound, and abort by a foreign message.
        send_msg(MSG_START_BURST_WR, 12'h0, 16'h0, 12'd0, 12'd3, 96'h0);
        get_rsp("size_h0", RSP_NAK, 16'h0);
        check("size_h0_inactive", 32'(burst_active), 0);
        send_msg(MSG_START_BURST_WR, 12'h0, 16'h0, 12'd4, 12'd0, 96'h0);
        get_rsp("size_w0", RSP_NAK, 16'h0);
        send_msg(MSG_START_BURST_WR, 12'h0, 16'h0, 12'd257, 12'd511, 96'h0);
        get_rsp("size_over", RSP_NAK, 16'h0);
        send_msg(MSG_START_BURST_WR, 12'h0, 16'h0, 12'd256, 12'd512, 96'h0);
        get_rsp("size_equal", RSP_ACK, 16'h0);
        check("size_equal_active", 32'(burst_active), 1);
        c0 = rd_cnt;
        send_msg(MSG_RGF_READ, 12'h005, 16'h0, 12'h0, 12'h0, 96'h0);
        get_rsp("abort", RSP_NAK, 16'h0);
        check("abort_inactive", 32'(burst_active), 0);
        check("abort_no_rgf_strobe", 32'(rd_cnt - c0), 0);
        run_burst("after_abort", 1, 5);

        // Burst read launch.
        c0 = start_cnt;
        send_msg(MSG_START_BURST_RD, 12'h0AB, 16'h0, 12'd4, 12'd5, 96'h0);
        get_rsp("brd", RSP_ACK, 16'h0);
        check("brd_starts", 32'(start_cnt - c0), 1);
        check("brd_h", 32'(st_h), 4);
        check("brd_w", 32'(st_w), 5);
        check("brd_addr", 32'(st_addr), 32'h0AB);
        c0 = start_cnt;
        send_msg(MSG_START_BURST_RD, 12'h0AB, 16'h0, 12'd4, 12'd0, 96'h0);
        get_rsp("brd_bad", RSP_NAK, 16'h0);
        check("brd_bad_no_start", 32'(start_cnt - c0), 0);

        // Message types that are illegal in IDLE.
        send_msg(MSG_BURST_PIXEL_WR, 12'h0, 16'h0, 12'h0, 12'h0, 96'h0);
        get_rsp("idle_pixel", RSP_NAK, 16'h0);
        send_msg(MSG_NONE, 12'h0, 16'h0, 12'h0, 12'h0, 96'h0);
        get_rsp("idle_none", RSP_NAK, 16'h0);
        send_msg(MSG_INVALID, 12'h0, 16'h0, 12'h0, 12'h0, 96'h0);
        get_rsp("idle_invalid", RSP_NAK, 16'h0);

        // Single pixel write uses pixel 0 only.
        pix_log.delete();
        rp = {$urandom, $urandom, $urandom};
        send_msg(MSG_SINGLE_PIXEL_WR, 12'h7FF, 16'h0, 12'h0, 12'h0, rp);
        get_rsp("single", RSP_ACK, 16'h0);
        check("single_count", 32'(pix_log.size()), 1);
        if (pix_log.size() > 0) begin
            check("single_addr", 32'(pix_log[0][40:24]), 32'h7FF);
            check("single_data", 32'(pix_log[0][23:0]), 32'(rp[23:0]));
        end

        // Reset in the middle of a burst.
        ready_mode = 1;
        send_msg(MSG_START_BURST_WR, 12'h0, 16'h0, 12'd2, 12'd3, 96'h0);
        get_rsp("rst_burst_start", RSP_ACK, 16'h0);
        send_msg(MSG_BURST_PIXEL_WR, 12'h0, 16'h0, 12'h0, 12'h0, {$urandom, $urandom, $urandom});
        tick();
        rst_n = 1'b0;
        #1;
        check("midburst_reset_outputs_zero", 32'(|{msg_ready, rgf_wr_en, rgf_rd_en, rgf_addr,
              rgf_wdata, pix_wr_en, pix_wr_addr, pix_wr_data, rd_start, rd_h, rd_w, rd_addr,
              rsp_valid, rsp_type, rsp_data, burst_active}), 0);
        ready_mode = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_reset_no_rsp", 32'(rsp_valid), 0);
        check("post_reset_inactive", 32'(burst_active), 0);
        send_msg(MSG_RGF_WRITE, 12'h0C3, 16'h5A5A, 12'h0, 12'h0, 96'h0);
        check("post_reset_wr_strobe", 32'(rgf_wr_en), 1);
        check("post_reset_wr_data", 32'(rgf_wdata), 32'h5A5A);
        get_rsp("post_reset_wr", RSP_ACK, 16'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
